serial_compare_ctrl: RTL and testbench

- Sequencer that compares two WIDTH-bit operands by time-sharing a single external 2-bit comparator slice, one bit-pair per cycle, MSB pair first.
- Lets wide magnitude compares reuse the team's 2-bit comparator cell instead of replicating it.
- Operands and start enter from the requesting logic. The controller drives the slice inputs and samples its three outputs. A registered result is returned with a done pulse.

---
 rtl/serial_compare_ctrl.sv | 120 ++++++++++++
 tb/tb_serial_compare_ctrl.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/serial_compare_ctrl.sv
// Wide magnitude compare built from one shared external 2-bit comparator slice, MSB pair first.
// Build option SERIAL_COMPARE_EARLY_EXIT_EN: stop on the first unequal pair instead of scanning all pairs.
module serial_compare_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [1:0]       slice_a,
  output logic [1:0]       slice_b,
  input  logic             slice_gt,
  input  logic             slice_lt,
  input  logic             slice_eq,
  output logic             busy,
  output logic             done,
  output logic             a_greater,
  output logic             a_less,
  output logic             a_equal
);

  localparam int N  = WIDTH / 2;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, COMPARE, DONE} state_t;

  state_t          state;
  logic [IW-1:0]   idx;
  logic [WIDTH-1:0] a_q, b_q;
  logic            last;

  // Equality is implied by neither gt nor lt, so the slice's eq output carries no extra information.
  logic slice_eq_unused;
  assign slice_eq_unused = slice_eq;

  assign last    = (idx == IW'(0));
  assign busy    = (state == COMPARE);
  assign done    = (state == DONE);
  assign slice_a = (state == COMPARE) ? a_q[{idx, 1'b0} +: 2] : 2'b00;
  assign slice_b = (state == COMPARE) ? b_q[{idx, 1'b0} +: 2] : 2'b00;

`ifndef SERIAL_COMPARE_EARLY_EXIT_EN
  // First unequal pair seen during the full scan; later pairs cannot override it.
  logic dec_vld, dec_gt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      a_greater <= 1'b0;
      a_less    <= 1'b0;
      a_equal   <= 1'b0;
`ifndef SERIAL_COMPARE_EARLY_EXIT_EN
      dec_vld   <= 1'b0;
      dec_gt    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q       <= a_in;
            b_q       <= b_in;
            a_greater <= 1'b0;
            a_less    <= 1'b0;
            a_equal   <= 1'b0;
            idx       <= IW'(N - 1);
`ifndef SERIAL_COMPARE_EARLY_EXIT_EN
            dec_vld   <= 1'b0;
            dec_gt    <= 1'b0;
`endif
            state     <= COMPARE;
          end
        end
        COMPARE: begin
`ifdef SERIAL_COMPARE_EARLY_EXIT_EN
          if (slice_gt) begin
            a_greater <= 1'b1;
            state     <= DONE;
          end else if (slice_lt) begin
            a_less    <= 1'b1;
            state     <= DONE;
          end else if (last) begin
            a_equal   <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx - IW'(1);
          end
`else
          if (last) begin
            state <= DONE;
            if (dec_vld) begin
              a_greater <= dec_gt;
              a_less    <= !dec_gt;
            end else if (slice_gt) begin
              a_greater <= 1'b1;
            end else if (slice_lt) begin
              a_less    <= 1'b1;
            end else begin
              a_equal   <= 1'b1;
            end
          end else begin
            idx <= idx - IW'(1);
            if (!dec_vld && (slice_gt || slice_lt)) begin
              dec_vld <= 1'b1;
              dec_gt  <= slice_gt;
            end
          end
`endif
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_compare_ctrl.sv
// Directed plus random bench for serial_compare_ctrl with an ideal 2-bit comparator slice.
module tb_serial_compare_ctrl;
  localparam int WIDTH = 8;
  localparam int N     = WIDTH / 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a_in = '0, b_in = '0;
  logic [1:0]       slice_a, slice_b;
  logic             slice_gt, slice_lt, slice_eq;
  logic             busy, done, a_greater, a_less, a_equal;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // Ideal comparator slice
  assign slice_gt = slice_a > slice_b;
  assign slice_lt = slice_a < slice_b;
  assign slice_eq = slice_a == slice_b;

  serial_compare_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a_in(a_in), .b_in(b_in),
    .slice_a(slice_a), .slice_b(slice_b),
    .slice_gt(slice_gt), .slice_lt(slice_lt), .slice_eq(slice_eq),
    .busy(busy), .done(done),
    .a_greater(a_greater), .a_less(a_less), .a_equal(a_equal)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Number of COMPARE cycles the reference expects for these operands.
  function automatic int ref_cycles(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int k;
    k = N;
`ifdef SERIAL_COMPARE_EARLY_EXIT_EN
    for (int p = N - 1; p >= 0; p--) begin
      if (((a >> (2 * p)) & 3) != ((b >> (2 * p)) & 3)) begin
        k = N - p;
        break;
      end
    end
`endif
    return k;
  endfunction

  // Caller sits at a negedge; start is presented in that cycle and accepted at the next posedge.
  // hold_start keeps start high (and scrambles a_in) while the compare is in flight.
  task automatic run_cmp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit hold_start);
    int cyc, k;
    logic [2:0] exp_res;
    k = ref_cycles(a, b);
    exp_res = (a > b) ? 3'b100 : (a < b) ? 3'b010 : 3'b001;
    start = 1'b1; a_in = a; b_in = b;
    @(negedge clk);
    if (hold_start) a_in = '0;
    else start = 1'b0;
    cyc = 1;
    check("cleared_on_accept", {a_greater, a_less, a_equal}, 3'b000);
    while (done !== 1'b1 && cyc <= N + 3) begin
      check("busy", busy, 1'b1);
      check("slice_a", slice_a, (a >> (2 * (N - cyc))) & 3);
      check("slice_b", slice_b, (b >> (2 * (N - cyc))) & 3);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("done_cycle", cyc, k + 1);
    check("busy_in_done", busy, 1'b0);
    check("result", {a_greater, a_less, a_equal}, exp_res);
    @(negedge clk);
    check("done_pulse", done, 1'b0);
    check("result_hold", {a_greater, a_less, a_equal}, exp_res);
  endtask

  initial begin
    logic [WIDTH-1:0] ra, rb;
    // Reset state
    #1;
    check("reset_outs", {busy, done, a_greater, a_less, a_equal, slice_a, slice_b}, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_outs", {busy, done, a_greater, a_less, a_equal, slice_a, slice_b}, 0);

    // Equal operands
    run_cmp(8'h5A, 8'h5A, 1'b0);
    @(negedge clk);
    // MSB pair decides greater
    run_cmp(8'hC0, 8'h40, 1'b0);
    @(negedge clk);
    // LSB pair decides less, then result holds through idle
    run_cmp(8'h12, 8'h13, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_hold", {busy, done, a_greater, a_less, a_equal}, 5'b00010);
    end

    // Start held during compare, operand changes after capture
    run_cmp(8'h80, 8'h7F, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("no_second_op", {busy, done, a_greater}, 3'b001);
    end

    // Mid-operation reset
    start = 1'b1; a_in = 8'h11; b_in = 8'h11;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_reset", {busy, done, a_greater, a_less, a_equal, slice_a, slice_b}, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("no_done_in_reset", done, 1'b0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("no_done_after_reset", {busy, done}, 2'b00);
    run_cmp(8'h01, 8'h02, 1'b0);

    // Back-to-back: new start in the cycle right after done
    run_cmp(8'hFF, 8'h00, 1'b0);
    run_cmp(8'h3C, 8'h3D, 1'b0);
    run_cmp(8'h00, 8'h00, 1'b0);

    // Random operands, sometimes sharing upper pairs to exercise deeper scans
    for (int i = 0; i < 30; i++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      if ($urandom_range(0, 1) == 1) rb = (ra & 8'hF0) | (rb & 8'h0F);
      if ($urandom_range(0, 7) == 0) rb = ra;
      if ($urandom_range(0, 1) == 1) @(negedge clk);
      run_cmp(ra, rb, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench did not finish");
  end
endmodule
